// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
//   Shared types for the shared serial pattern detector and its scheduler.
//   - det_state_t : states of the serial "101"/"110" Moore detector
//   - ctrl_state_t: states of the scheduler controller
//   - det_next    : detector next-state function
//   - is_match    : detector Moore output decode
// ---------------------------------------------------------------------------
package seq_detect_pkg;

    // Each state names the relevant suffix of the bits seen since the last clear.
    typedef enum logic [2:0] {
        ZERO         = 3'b000,
        ONE          = 3'b001,
        ONE_ZERO     = 3'b011,
        ONE_ONE      = 3'b010,
        ONE_ZERO_ONE = 3'b110,
        ONE_ONE_ZERO = 3'b111
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        RESP  = 2'd3
    } ctrl_state_t;

    // Overlapping matches: after "101" a 1 leaves suffix "11", a 0 leaves "10";
    // after "110" a 1 completes "101" directly.
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        n = ZERO;
        case (s)
            ZERO:         n = b ? ONE          : ZERO;
            ONE:          n = b ? ONE_ONE      : ONE_ZERO;
            ONE_ZERO:     n = b ? ONE_ZERO_ONE : ZERO;
            ONE_ONE:      n = b ? ONE_ONE      : ONE_ONE_ZERO;
            ONE_ZERO_ONE: n = b ? ONE_ONE      : ONE_ZERO;
            ONE_ONE_ZERO: n = b ? ONE_ZERO_ONE : ZERO;
            default:      n = ZERO;
        endcase
        return n;
    endfunction

    function automatic logic is_match(input det_state_t s);
        return (s == ONE_ZERO_ONE) || (s == ONE_ONE_ZERO);
    endfunction

endpackage

// File: rtl/serial_pattern_fsm.sv
// ---------------------------------------------------------------------------
// serial_pattern_fsm
//   Moore detector for the serial patterns "101" and "110" (overlapping).
//   Ports:
//     clock        : rising-edge clock
//     reset        : asynchronous active-low reset (state -> ZERO)
//     clear        : synchronous clear to ZERO, wins over the sample
//     sequence_in  : serial bit sampled on each rising edge
//     detector_out : 1 iff the last three sampled bits are 101 or 110
// ---------------------------------------------------------------------------
module serial_pattern_fsm
    import seq_detect_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic sequence_in,
    output logic detector_out
);

    det_state_t state_reg;
    det_state_t state_next;

    always_comb begin
        state_next = det_next(state_reg, sequence_in);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ZERO;
        end else if (clear) begin
            state_reg <= ZERO;
        end else begin
            state_reg <= state_next;
        end
    end

    assign detector_out = is_match(state_reg);

endmodule

// File: rtl/seq_detect_scheduler.sv
// ---------------------------------------------------------------------------
// seq_detect_scheduler
//   Round-robin shares one serial pattern detector among N requesters. A
//   granted W-bit word is shifted MSB first through the detector; the hit
//   count is returned with the requester index on a valid/ready port.
//   Ports:
//     clock, reset      : clock / asynchronous active-low reset
//     req_valid [N]     : per-requester word valid
//     req_data  [N*W]   : word of requester i in bits [i*W +: W]
//     req_ready [N]     : one-hot single-cycle grant pulse
//     rsp_valid         : result available (RESP state)
//     rsp_ready         : result consumer accepts
//     rsp_id    [ID_W]  : requester owning the result
//     rsp_count [CNT_W] : detector hits in the word
//     busy              : controller not in IDLE
// ---------------------------------------------------------------------------
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int ID_W  = $clog2(N),
    parameter int CNT_W = $clog2(W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [CNT_W-1:0] rsp_count,
    output logic             busy
);

    localparam int IDX_W = $clog2(W);

    ctrl_state_t      state_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [W-1:0]     shift_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [CNT_W-1:0] count_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    // Low during reset and for the first cycle after release; keeps the
    // combinational grant path quiet while reset is asserted.
    logic             armed_reg;

    logic [W-1:0]     word [N];
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_fire;
    logic             det_clear;
    logic             det_out;

    for (genvar gi = 0; gi < N; gi++) begin : g_word
        assign word[gi] = req_data[gi*W +: W];
    end

    // First valid requester at or after the pointer, wrapping past N-1.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // The grant is issued in the IDLE cycle itself so a word is accepted in
    // the same cycle the decision is made (grant-to-result latency W+2).
    assign grant_fire = (state_reg == IDLE) && armed_reg && grant_found;

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign req_ready[gi] = grant_fire && (grant_idx == ID_W'(gi));
    end

    // Holding the detector cleared throughout IDLE guarantees it starts from
    // ZERO at every grant, so no match can straddle two words.
    assign det_clear = (state_reg == IDLE);

    serial_pattern_fsm u_detector (
        .clock        (clock),
        .reset        (reset),
        .clear        (det_clear),
        .sequence_in  (shift_reg[W-1]),
        .detector_out (det_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            count_reg   <= '0;
            rsp_id_reg  <= '0;
            armed_reg   <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        shift_reg   <= word[grant_idx];
                        rsp_id_reg  <= grant_idx;
                        count_reg   <= '0;
                        bit_idx_reg <= '0;
                        ptr_reg     <= (grant_idx == ID_W'(N-1)) ? '0 : grant_idx + ID_W'(1);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // detector_out lags the shifted bit by one cycle; at k=0
                    // it still shows the cleared state.
                    if (det_out && (bit_idx_reg != '0)) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                    shift_reg <= {shift_reg[W-2:0], 1'b0};
                    if (bit_idx_reg == IDX_W'(W-1)) begin
                        state_reg <= FLUSH;
                    end else begin
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                    end
                end
                FLUSH: begin
                    // Picks up a match ending on the last bit of the word.
                    if (det_out) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_count = count_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_scheduler
//   Directed and randomized stimulus for seq_detect_scheduler, checked against
//   a behavioural model (pattern count over the bit string, round-robin pick).
// ---------------------------------------------------------------------------
module tb_seq_detect_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ID_W  = 2;
    localparam int CNT_W = 3;

    logic             clock     = 1'b0;
    logic             reset     = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data  = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [ID_W-1:0]  rsp_id;
    logic [CNT_W-1:0] rsp_count;
    logic             busy;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int ptr        = 0;
    int last_grant = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seq_detect_scheduler #(.N(N), .W(W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hits = number of 3-bit windows of the MSB-first bit string equal to 101 or 110.
    function automatic int model_count(input logic [W-1:0] w);
        int c;
        logic [2:0] t;
        c = 0;
        for (int i = 2; i < W; i++) begin
            t = {w[W+1-i], w[W-i], w[W-1-i]};
            if (t == 3'b101 || t == 3'b110) c++;
        end
        return c;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One full transaction: wait for grant, follow to result, optional stall, accept.
    task automatic xact(input bit drop, input bit renew, input int stall, input int gap);
        int g;
        int n;
        int cnt;
        logic [W-1:0] wd;
        logic [N-1:0] oh;
        bit rdy_bad;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            step();
            #1;
            n++;
        end
        chk("grant_seen", 32'(|req_ready), 1);
        if (req_ready == '0) return;
        g  = model_pick(req_valid, ptr);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("grant_onehot", 32'(req_ready), 32'(oh));
        if (gap > 0) chk("grant_gap", cyc - last_grant, gap);
        if (g < 0) g = 0;
        last_grant = cyc;
        wd  = req_data[g*W +: W];
        cnt = model_count(wd);
        ptr = (g + 1) % N;
        step();
        if (drop)  req_valid[g] = 1'b0;
        if (renew) req_data[g*W +: W] = W'($urandom);
        #1;
        n = 0;
        rdy_bad = 1'b0;
        while (!rsp_valid && n < 40) begin
            if (req_ready != '0) rdy_bad = 1'b1;
            step();
            #1;
            n++;
        end
        chk("no_grant_while_busy", 32'(rdy_bad), 0);
        chk("rsp_seen", 32'(rsp_valid), 1);
        chk("latency", cyc - last_grant, W + 2);
        chk("rsp_id", 32'(rsp_id), g);
        chk("rsp_count", 32'(rsp_count), cnt);
        chk("busy_in_resp", 32'(busy), 1);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_id", 32'(rsp_id), g);
            chk("hold_count", 32'(rsp_count), cnt);
            chk("hold_no_grant", 32'(req_ready), 0);
        end
        $display("xact id=%0d word=%b count=%0d stall=%0d", g, wd, cnt, stall);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("released_valid", 32'(rsp_valid), 0);
        chk("released_idle", 32'(busy), 0);
    endtask

    initial begin
        int n;
        // Reset state, with requests pending to show the grant is held off.
        req_valid = 4'b1111;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_count", 32'(rsp_count), 0);
        chk("rst_busy", 32'(busy), 0);
        req_valid = '0;
        reset = 1'b1;
        step();

        // Single requester, directed words.
        req_data[0*W +: W] = 8'b1011_0110; req_valid = 4'b0001; xact(1, 0, 0, 0);
        req_data[0*W +: W] = 8'b1010_1010; req_valid = 4'b0001; xact(1, 0, 0, 0);
        req_data[0*W +: W] = 8'h00;        req_valid = 4'b0001; xact(1, 0, 0, 0);
        req_data[0*W +: W] = 8'hFF;        req_valid = 4'b0001; xact(1, 0, 0, 0);

        // No cross-word match.
        req_data[1*W +: W] = 8'h03; req_valid = 4'b0010; xact(1, 0, 0, 0);
        req_data[1*W +: W] = 8'h00; req_valid = 4'b0010; xact(1, 0, 0, 0);

        // Bring pointer to 0, then all four valid: 0,1,2,3,0 back to back.
        req_data[3*W +: W] = W'($urandom); req_valid = 4'b1000; xact(1, 0, 0, 0);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_valid = 4'b1111;
        xact(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) xact(0, 0, 0, W + 3);
        // Only 0 and 2 valid with pointer at 1: 2 then 0.
        req_valid = 4'b0101;
        xact(0, 0, 0, W + 3);
        xact(0, 0, 0, W + 3);

        // Backpressure with other requests pending, then the next grant.
        req_valid = 4'b1111;
        xact(0, 0, 5, W + 3);
        xact(0, 0, 0, W + 8);
        req_valid = '0;

        // Randomized traffic.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) req_data[i*W +: W] = W'($urandom);
            end
            req_valid = N'($urandom_range(1, 15));
            xact(0, 1, $urandom_range(0, 3), 0);
        end
        req_valid = '0;
        step();

        // Reset in the middle of a word (SHIFT k=4).
        req_data[1*W +: W] = 8'b1011_0110;
        req_data[3*W +: W] = W'($urandom);
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            step();
            #1;
            n++;
        end
        chk("pre_reset_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = 4'b1010;
        repeat (4) step();
        chk("pre_reset_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rsp_id", 32'(rsp_id), 0);
        chk("midrst_rsp_count", 32'(rsp_count), 0);
        chk("midrst_busy", 32'(busy), 0);
        step();
        step();
        chk("midrst_no_result", 32'(rsp_valid), 0);
        reset = 1'b1;
        ptr = 0;
        xact(1, 0, 0, 0);
        req_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
